// File: rtl/execute_stage_cc.sv
// RV32 execute stage: operand forwarding, ALU, branch resolution and the
// EX/MEM pipeline register feeding the memory stage.
module execute_stage_cc #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            ResultSrcE,
  input  logic            MemWriteE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [3:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [4:0]      RDE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            ResultSrcM,
  output logic            MemWriteM,
  output logic [4:0]      RDM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_WB    = 2'b01,
    FWD_MEM   = 2'b10,
    FWD_RSVD  = 2'b11
  } fwd_sel_e;

  logic            r_regwrite;
  logic            r_resultsrc;
  logic            r_memwrite;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_aluresult;
  logic [XLEN-1:0] r_writedata;

  logic [XLEN-1:0] w_srca;
  logic [XLEN-1:0] w_writedata;
  logic [XLEN-1:0] w_srcb;
  logic [XLEN-1:0] w_aluresult;
  logic [4:0]      w_shamt;
  logic            w_zero;
  logic            w_slt;
  logic            w_sltu;

  // Forwarding from M uses the registered result, so there is no loop back through the ALU.
  always_comb begin
    w_srca = RD1E;
    case (ForwardAE)
      FWD_WB:  w_srca = ResultW;
      FWD_MEM: w_srca = r_aluresult;
      default: w_srca = RD1E;
    endcase
  end

  always_comb begin
    w_writedata = RD2E;
    case (ForwardBE)
      FWD_WB:  w_writedata = ResultW;
      FWD_MEM: w_writedata = r_aluresult;
      default: w_writedata = RD2E;
    endcase
  end

  assign w_srcb  = ALUSrcE ? ImmExtE : w_writedata;
  assign w_shamt = w_srcb[4:0];
  assign w_slt   = $signed(w_srca) < $signed(w_srcb);
  assign w_sltu  = w_srca < w_srcb;

  always_comb begin
    w_aluresult = '0;
    case (ALUControlE)
      ALU_ADD:  w_aluresult = w_srca + w_srcb;
      ALU_SUB:  w_aluresult = w_srca - w_srcb;
      ALU_AND:  w_aluresult = w_srca & w_srcb;
      ALU_OR:   w_aluresult = w_srca | w_srcb;
      ALU_XOR:  w_aluresult = w_srca ^ w_srcb;
      ALU_SLT:  w_aluresult = {{(XLEN-1){1'b0}}, w_slt};
      ALU_SLTU: w_aluresult = {{(XLEN-1){1'b0}}, w_sltu};
      ALU_SLL:  w_aluresult = w_srca << w_shamt;
      ALU_SRL:  w_aluresult = w_srca >> w_shamt;
      ALU_SRA:  w_aluresult = $unsigned($signed(w_srca) >>> w_shamt);
      default:  w_aluresult = '0;
    endcase
  end

  assign w_zero    = (w_aluresult == '0);
  assign PCSrcE    = BranchE & w_zero;
  assign PCTargetE = PCE + ImmExtE;

  // Store data is the forwarded RD2, never the immediate-muxed SrcB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regwrite  <= 1'b0;
      r_resultsrc <= 1'b0;
      r_memwrite  <= 1'b0;
      r_rd        <= '0;
      r_aluresult <= '0;
      r_writedata <= '0;
    end else begin
      r_regwrite  <= RegWriteE;
      r_resultsrc <= ResultSrcE;
      r_memwrite  <= MemWriteE;
      r_rd        <= RDE;
      r_aluresult <= w_aluresult;
      r_writedata <= w_writedata;
    end
  end

  assign RegWriteM  = r_regwrite;
  assign ResultSrcM = r_resultsrc;
  assign MemWriteM  = r_memwrite;
  assign RDM        = r_rd;
  assign ALUResultM = r_aluresult;
  assign WriteDataM = r_writedata;

endmodule

// File: tb/tb_execute_stage_cc.sv
// Scoreboard bench for execute_stage_cc: driver pushes predicted EX/MEM
// contents, a monitor pops and compares after each rising edge.
module tb_execute_stage_cc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWriteE = 1'b0, ResultSrcE = 1'b0, MemWriteE = 1'b0;
  logic        BranchE = 1'b0, ALUSrcE = 1'b0;
  logic [3:0]  ALUControlE = '0;
  logic [31:0] RD1E = '0, RD2E = '0, PCE = '0, ImmExtE = '0, ResultW = '0;
  logic [4:0]  RDE = '0;
  logic [1:0]  ForwardAE = '0, ForwardBE = '0;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, ResultSrcM, MemWriteM;
  logic [4:0]  RDM;
  logic [31:0] ALUResultM, WriteDataM;

  execute_stage_cc #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .RDE(RDE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .RDM(RDM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, rs, mw, br, alusrc;
    logic [3:0]  op;
    logic [31:0] rd1, rd2, pc, imm, resw;
    logic [4:0]  rd;
    logic [1:0]  fa, fb;
  } stim_t;

  typedef struct {
    logic        rw, rs, mw;
    logic [4:0]  rd;
    logic [31:0] alu, wd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_alu = '0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << sh;
      4'd8: return a >> sh;
      4'd9: return a[31] ? ~((~a) >> sh) : (a >> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] reg_v, input logic [31:0] w_v);
    if (sel == 2'd1) return w_v;
    if (sel == 2'd2) return m_alu;
    return reg_v;
  endfunction

  task automatic apply(input stim_t s);
    logic [31:0] a, wd, b, res;
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    RegWriteE = s.rw; ResultSrcE = s.rs; MemWriteE = s.mw; BranchE = s.br;
    ALUSrcE = s.alusrc; ALUControlE = s.op; RD1E = s.rd1; RD2E = s.rd2;
    PCE = s.pc; ImmExtE = s.imm; ResultW = s.resw; RDE = s.rd;
    ForwardAE = s.fa; ForwardBE = s.fb;
    a   = fwd(s.fa, s.rd1, s.resw);
    wd  = fwd(s.fb, s.rd2, s.resw);
    b   = s.alusrc ? s.imm : wd;
    res = alu_ref(s.op, a, b);
    #1;
    chk("PCSrcE", {31'd0, PCSrcE}, {31'd0, s.br && (res == 32'd0)});
    chk("PCTargetE", PCTargetE, s.pc + s.imm);
    e.rw = s.rw; e.rs = s.rs; e.mw = s.mw; e.rd = s.rd; e.alu = res; e.wd = wd;
    sb.push_back(e);
    m_alu = res;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rw = 1'($urandom); s.rs = 1'($urandom); s.mw = 1'($urandom);
    s.br = 1'($urandom); s.alusrc = 1'($urandom);
    s.op = 4'($urandom_range(0, 15));
    s.rd1 = $urandom; s.rd2 = $urandom; s.pc = $urandom; s.imm = $urandom;
    s.resw = $urandom; s.rd = 5'($urandom);
    s.fa = 2'($urandom); s.fb = 2'($urandom);
    return s;
  endfunction

  function automatic stim_t plain(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    stim_t s;
    s = '{rw: 1'b1, rs: 1'b0, mw: 1'b0, br: 1'b0, alusrc: 1'b0, op: op,
          rd1: a, rd2: b, pc: '0, imm: '0, resw: '0, rd: rd, fa: 2'd0, fb: 2'd0};
    return s;
  endfunction

  task automatic check_m_zero(input string tag);
    chk({tag, "_RegWriteM"}, {31'd0, RegWriteM}, 32'd0);
    chk({tag, "_ResultSrcM"}, {31'd0, ResultSrcM}, 32'd0);
    chk({tag, "_MemWriteM"}, {31'd0, MemWriteM}, 32'd0);
    chk({tag, "_RDM"}, {27'd0, RDM}, 32'd0);
    chk({tag, "_ALUResultM"}, ALUResultM, 32'd0);
    chk({tag, "_WriteDataM"}, WriteDataM, 32'd0);
  endtask

  // Monitor: every rising edge out of reset presents one EX/MEM bundle.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("RegWriteM", {31'd0, RegWriteM}, {31'd0, e.rw});
      chk("ResultSrcM", {31'd0, ResultSrcM}, {31'd0, e.rs});
      chk("MemWriteM", {31'd0, MemWriteM}, {31'd0, e.mw});
      chk("RDM", {27'd0, RDM}, {27'd0, e.rd});
      chk("ALUResultM", ALUResultM, e.alu);
      chk("WriteDataM", WriteDataM, e.wd);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "timeout");
  end

  logic [31:0] sweep_exp [16];

  initial begin
    stim_t s;
    // Reset with random inputs: M stays zero before and at the first edge.
    s = rand_stim();
    RD1E = s.rd1; RD2E = s.rd2; RegWriteE = 1'b1; MemWriteE = 1'b1; RDE = 5'd17;
    ALUControlE = 4'd0; ResultW = s.resw;
    #2;
    check_m_zero("rst_pre");
    @(posedge clk); #1;
    check_m_zero("rst_edge");
    m_alu = '0;
    apply(plain(4'd0, 32'd5, 32'd7, 5'd3));
    @(posedge clk); #2;
    chk("rst_add", ALUResultM, 32'd12);
    chk("rst_rd", {27'd0, RDM}, 32'd3);

    // Forwarding from M with immediate, then B from W into store data.
    apply(plain(4'd0, 32'd10, 32'd20, 5'd1));
    s = plain(4'd0, 32'hDEAD, 32'd0, 5'd2);
    s.fa = 2'b10; s.imm = 32'd4; s.alusrc = 1'b1;
    apply(s);
    @(posedge clk); #2;
    chk("fwd_m", ALUResultM, 32'd34);
    s.fb = 2'b01; s.resw = 32'h55; s.mw = 1'b1; s.rd2 = 32'h1234;
    apply(s);
    @(posedge clk); #2;
    chk("fwd_w_store", WriteDataM, 32'h55);
    // Select 11 behaves as 00; A from M with B from W simultaneously.
    s = plain(4'd0, 32'h100, 32'h200, 5'd4); s.fa = 2'b11; s.fb = 2'b11;
    apply(s);
    s = plain(4'd2, 32'h0, 32'h0, 5'd5); s.fa = 2'b10; s.fb = 2'b01; s.resw = 32'hF0F;
    apply(s);

    // Branch resolution.
    s = plain(4'd1, 32'd9, 32'd9, 5'd0); s.rw = 1'b0; s.br = 1'b1;
    s.pc = 32'h100; s.imm = 32'hFFFF_FFF0;
    apply(s);
    chk("br_taken", {31'd0, PCSrcE}, 32'd1);
    chk("br_target", PCTargetE, 32'hF0);
    s.rd2 = 32'd8;
    apply(s);
    chk("br_not_taken", {31'd0, PCSrcE}, 32'd0);

    // Sweep every ALU code on 0x80000000 and 1.
    sweep_exp = '{32'h8000_0001, 32'h7FFF_FFFF, 32'h0, 32'h8000_0001, 32'h8000_0001,
                  32'h1, 32'h0, 32'h0, 32'h4000_0000, 32'hC000_0000,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 16; i++) begin
      apply(plain(4'(i), 32'h8000_0000, 32'd1, 5'(i)));
      @(posedge clk); #2;
      chk($sformatf("sweep_op%0d", i), ALUResultM, sweep_exp[i]);
    end
    apply(plain(4'd9, 32'h8000_0000, 32'd31, 5'd9));
    @(posedge clk); #2;
    chk("sra31", ALUResultM, 32'hFFFF_FFFF);
    apply(plain(4'd8, 32'h8000_0000, 32'd31, 5'd8));
    @(posedge clk); #2;
    chk("srl31", ALUResultM, 32'h0000_0001);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      s = rand_stim();
      if (($urandom % 4) == 0) begin s.op = 4'd1; s.rd2 = s.rd1; s.fa = 2'd0; s.fb = 2'd0; s.alusrc = 1'b0; end
      apply(s);
    end

    // Bubbles, then asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) begin
      s = rand_stim(); s.rw = 1'b0; s.rs = 1'b0; s.mw = 1'b0; s.br = 1'b0;
      apply(s);
    end
    @(posedge clk); #2;
    chk("bubble_rw", {31'd0, RegWriteM}, 32'd0);
    chk("bubble_mw", {31'd0, MemWriteM}, 32'd0);
    s = rand_stim(); s.rw = 1'b1; s.mw = 1'b1; s.rd = 5'd31; s.rd1 = 32'hFFFF_0000; s.op = 4'd0;
    apply(s);
    @(posedge clk); #2;
    s = rand_stim(); s.rw = 1'b1; s.rd = 5'd7;
    apply(s);
    rst = 1'b1;
    sb.delete();
    m_alu = '0;
    #1;
    check_m_zero("rst_async");
    @(posedge clk); #2;
    check_m_zero("rst_hold");
    for (int i = 0; i < 20; i++) apply(rand_stim());
    @(posedge clk); #3;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/execute_stage_cc.md
# execute_stage_cc

Execute stage of the five-stage RV32 pipeline. It sits directly downstream of the decode stage and consumes the registered ID/EX bundle: control bits, operands, PC, immediate and register indices. It forwards operands, computes the ALU result and branch target, and resolves branches. Its outputs are registered into the EX/MEM bundle consumed by the memory stage.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports (clock and reset first):
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE  input  1 each  ID/EX control bits.
- ALUControlE  input  4  ALU operation select.
- RD1E, RD2E  input  XLEN  register-file operands.
- PCE, ImmExtE  input  XLEN  instruction PC and sign-extended immediate.
- RDE  input  5  destination register index.
- ForwardAE, ForwardBE  input  2  forwarding selects from the hazard unit.
- ResultW  input  XLEN  writeback-stage result, used for forwarding.
- PCSrcE  output  1  branch taken (combinational) to the fetch stage.
- PCTargetE  output  XLEN  branch target (combinational) to the fetch stage.
- RegWriteM, ResultSrcM, MemWriteM  output  1 each  registered control bits.
- RDM  output  5  registered destination index.
- ALUResultM  output  XLEN  registered ALU result.
- WriteDataM  output  XLEN  registered store data.

## Operation
- Operand A mux, selected by ForwardAE:
  - 00: RD1E
  - 01: ResultW
  - 10: ALUResultM
  - 11: RD1E
- Operand B forward mux: same selection on RD2E, driven by ForwardBE. Its output is WriteDataE.
- SrcB = ALUSrcE ? ImmExtE : WriteDataE.
- ALU, all arithmetic mod 2^32:
  - 0000 ADD
  - 0001 SUB
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLT: signed; result 1 or 0, zero-extended.
  - 0110 SLTU: unsigned; result 1 or 0, zero-extended.
  - 0111 SLL
  - 1000 SRL
  - 1001 SRA: sign-filling.
  - Shifts use SrcB[4:0] only.
  - Codes 1010–1111 produce 0.
- ZeroE = (ALUResultE == 0).
- PCSrcE = BranchE & ZeroE. BEQ is encoded as SUB by the control unit.
- PCTargetE = PCE + ImmExtE, wrap-around mod 2^32.
- EX/MEM register captures every clock:
  - RegWriteE, ResultSrcE, MemWriteE
  - RDE
  - ALUResultE
  - WriteDataE (forwarded RD2, not SrcB)
- No stall or flush inputs. A squashed instruction arrives with all control bits at 0 and propagates as a bubble.
- ALUResultM feeds the forward muxes. Forwarding from M therefore uses the previous instruction's registered result, with no combinational loop.

## Timing
- Combinational path E→E: forwarding mux, ALU, PCSrcE, PCTargetE valid within the same cycle as the ID/EX bundle.
- Latency from E inputs to M outputs: 1 cycle.
- Reset (asynchronous assert, synchronous release at the next edge): RegWriteM, ResultSrcM, MemWriteM, RDM, ALUResultM and WriteDataM all read 0.
- During reset, PCSrcE and PCTargetE follow their inputs combinationally. Upstream holds BranchE=0, so PCSrcE=0.
- Reset asserted mid-operation clears the M register immediately, with no clock edge needed. The instruction in flight is lost.
- Boundary conditions:
  - Forwarding select 11 behaves as 00.
  - ALUSrcE=1 overrides ForwardBE for SrcB only; WriteDataM still takes the forwarded value.
  - Simultaneous forward of A from M and B from W is legal and independent.
  - SRA of 0x80000000 by 31 gives 0xFFFFFFFF.
  - SLT of 0x80000000 vs 1 gives 1; SLTU of the same operands gives 0.

## Test plan
- Reset: assert rst with random inputs, then release → all M outputs 0 before and at the first edge; after the edge with ADD 5+7, RDE=3 → ALUResultM=12, RDM=3.
- Forwarding: cycle 1, ADD 10+20, RDE=1. Cycle 2, ForwardAE=10, RD1E=0xDEAD, ImmExtE=4, ALUSrcE=1 → ALUResultM=34. Then ForwardBE=01, ResultW=0x55, MemWriteE=1 → WriteDataM=0x55.
- Branch: BranchE=1, SUB 9−9, PCE=0x100, ImmExtE=0xFFFFFFF0 → PCSrcE=1, PCTargetE=0xF0. Repeat with 9−8 → PCSrcE=0.
- ALU sweep: every code on 0x80000000 and 1:
  - ADD 0x80000001
  - SUB 0x7FFFFFFF
  - SLT 1
  - SLTU 0
  - SRA-by-31 0xFFFFFFFF
  - SRL-by-31 0x00000001
  - code 1111 gives 0.
- Bubble: all control 0 with random data → RegWriteM=MemWriteM=0. Then assert rst mid-stream → M outputs clear with no clock edge.
